imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Arbitrates a single-port, synchronous-read instruction memory between two requesters:
- the instruction fetch port (read-only);
- the debug/loader port (read and write), used to load programs and inspect memory.

Arbitration is round-robin, with one transaction issued per cycle and a fixed one-cycle response latency. Out-of-range and misaligned accesses are rejected with an error response. A fetch-side flush input discards a stale response on a branch redirect. The block sits between the core's fetch stage, the debug loader and the instruction memory array.

## Interface
Parameters:
- DEPTH, 256, memory depth in 32-bit words (power of two).
- AW, $clog2(DEPTH), width of the memory word index.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  32  fetch byte address
- f_flush  in  1  fetch redirect: kill fetch response, block new fetch
- f_rsp_valid  out  1  fetch response valid (no backpressure)
- f_rsp_rdata  out  32  fetch read data
- f_rsp_err  out  1  fetch access error
- d_req_valid  in  1  debug request valid
- d_req_ready  out  1  debug request accepted this cycle
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  32  debug byte address
- d_req_wdata  in  32  debug write data
- d_rsp_valid  out  1  debug response valid (reads and writes)
- d_rsp_rdata  out  32  debug read data (0 for writes)
- d_rsp_err  out  1  debug access error
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- **Handshake:** a request is accepted when valid & ready are both high in the same cycle.
  - Ready is combinational from valid, the arbitration pointer, f_flush and rst.
  - Requesters hold valid and payload stable until accepted.
- **Eligibility:** f_eligible = f_req_valid & ~f_flush; d_eligible = d_req_valid.
- **Arbitration:**
  - At most one grant per cycle.
  - When only one requester is eligible, it is granted.
  - When both are eligible, the requester not in last_q is granted.
  - last_q updates to the granted requester on every grant.
  - Result: a waiting requester is served within 2 cycles.
- **Address check:** err = (addr[1:0] != 0) | (addr[31:2] >= DEPTH).
  - Error accesses still complete the handshake.
  - They drive mem_en=0, so no memory access occurs and no write happens.
  - Their response carries err=1 and rdata=0.
- **Memory drive on a legal grant:**
  - mem_en=1 and mem_addr=addr[AW+1:2].
  - mem_we=d_req_we for a debug grant, 0 for a fetch grant.
  - mem_wdata=d_req_wdata for a debug grant, otherwise 0.
  - With no grant, all mem_* outputs are 0.
- **Response tracking:** registered state is pend_q (valid, owner, err, is_write).
- **Response routing (cycle after grant):**
  - The owner's rsp_valid is 1.
  - rdata = mem_rdata for a legal read; 0 for writes and errors.
  - err = err_q.
  - The non-owner's rsp_valid is 0 and its rdata is 0.
- **Flush:** while f_flush=1, f_rsp_valid is forced 0 and f_req_ready is 0. The killed response is dropped, not replayed. Debug traffic is unaffected.
- **Reset values:**
  - All rsp_valid, rsp_rdata, rsp_err and mem_* outputs are 0.
  - Both ready outputs are 0 while rst=1.
  - last_q = debug, so fetch wins the first tie.
  - pend_q is cleared.
  - A transaction whose response is due in the cycle rst is asserted is dropped.

## Timing
- **Latency:** accept in cycle N, response in cycle N+1. Error responses have the same N+1 timing.
- **Throughput:** one transaction per cycle total, back-to-back allowed. The response of N and the grant of N+1 coexist in the same cycle.
- **Alternation:** with continuous requests on both ports, grants alternate f, d, f, d…
- **Combinational paths:** mem_* outputs are combinational from the granted request. Response outputs are combinational from pend_q, mem_rdata and f_flush. There is no path from mem_rdata to any ready.
- **Flush timing:** f_flush in cycle C kills the fetch response due in C and blocks a fetch grant in C. A debug grant in C is still permitted.

## Test plan
- **Reset, then single fetch:** fetch 0x0000_0008 with mem[2]=0x0010_0093 → ready in cycle N, mem_en=1 and mem_addr=2 in N, f_rsp_valid=1 with rdata 0x0010_0093 and err=0 in N+1.
- **Contention:** both ports request continuously for 6 cycles after reset → grant order f,d,f,d,f,d; each response lands on the correct port one cycle after its grant.
- **Debug write then fetch readback:**
  - Debug write to 0x0000_0010 with data 0xDEAD_BEEF gives d_rsp_valid=1 with rdata 0.
  - A subsequent fetch of 0x10 returns 0xDEAD_BEEF.
- **Errors:**
  - Fetch of 0x0000_0402 (misaligned) and debug write to 0x0000_0400 (out of range, DEPTH=256) each give err=1, rdata=0 and mem_en=0.
  - The memory contents are unchanged.
- **Flush:** fetch accepted in N with f_flush=1 in N+1 → no f_rsp_valid in N+1 and f_req_ready=0 in N+1; a pending debug read in N+1 is granted and responds in N+2.
- **Reset mid-operation:** rst asserted in the cycle a debug read response is due → d_rsp_valid=0 and both readies 0 during reset; the first post-reset tie grants fetch.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
// Bundles every handshake and memory-bus signal of the instruction memory
// arbiter. Only the clock and reset stay outside as plain ports.
//   fetch port : f_req_valid/ready/addr, f_flush, f_rsp_valid/rdata/err
//   debug port : d_req_valid/ready/we/addr/wdata, d_rsp_valid/rdata/err
//   memory port: mem_en/we/addr/wdata driven out, mem_rdata returned
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding requesters and memory.
interface imem_port_arbiter_if #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
);
    logic          f_req_valid;
    logic          f_req_ready;
    logic [31:0]   f_req_addr;
    logic          f_flush;
    logic          f_rsp_valid;
    logic [31:0]   f_rsp_rdata;
    logic          f_rsp_err;

    logic          d_req_valid;
    logic          d_req_ready;
    logic          d_req_we;
    logic [31:0]   d_req_addr;
    logic [31:0]   d_req_wdata;
    logic          d_rsp_valid;
    logic [31:0]   d_rsp_rdata;
    logic          d_rsp_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  f_req_valid, f_req_addr, f_flush,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  mem_rdata,
        output f_req_ready, f_rsp_valid, f_rsp_rdata, f_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req_valid, f_req_addr, f_flush,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output mem_rdata,
        input  f_req_ready, f_rsp_valid, f_rsp_rdata, f_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares one single-port, synchronous-read instruction memory between the
// fetch port (read-only) and the debug/loader port (read/write). Arbitration
// is round-robin with at most one grant per cycle. Every response appears
// exactly one cycle after its grant. Misaligned or out-of-range accesses
// complete the handshake without touching memory and return err=1, rdata=0.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - imem_port_arbiter_if.slave. This carries the fetch and debug
//          request/response channels, f_flush and the memory strobe/address/
//          data signals.
module imem_port_arbiter #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_port_arbiter_if.slave    bus
);

    // Owner encoding shared by the round-robin pointer and the pending response
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DEBUG = 1'b1;

    logic        last_q;
    logic        pend_valid_q;
    logic        pend_owner_q;
    logic        pend_err_q;
    logic        pend_write_q;

    logic        f_elig;
    logic        d_elig;
    logic        grant_f;
    logic        grant_d;
    logic        grant_any;
    logic [31:0] gnt_addr;
    logic        gnt_err;
    logic        gnt_write;

    logic        rsp_live;
    logic        f_live;
    logic        d_live;
    logic [31:0] rsp_data;

    // For a power-of-two depth, "word index >= DEPTH" reduces to any set bit
    // above the index field.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) | (a[31:AW+2] != '0);
    endfunction

    // Eligibility and grant. Reset blocks both grants, so both readies are low.
    // On a tie, the requester that did not win last time is granted.
    always_comb begin
        f_elig    = bus.f_req_valid & ~bus.f_flush & ~rst;
        d_elig    = bus.d_req_valid & ~rst;
        grant_f   = f_elig & (~d_elig | (last_q == OWN_DEBUG));
        grant_d   = d_elig & ~grant_f;
        grant_any = grant_f | grant_d;
        gnt_addr  = grant_d ? bus.d_req_addr : bus.f_req_addr;
        gnt_err   = grant_any & addr_err(gnt_addr);
        gnt_write = grant_d & bus.d_req_we;

        bus.f_req_ready = grant_f;
        bus.d_req_ready = grant_d;
    end

    // The memory is driven straight from the granted request. Error grants
    // still complete the handshake but leave the memory untouched.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (grant_any && !gnt_err) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = gnt_write;
            bus.mem_addr  = gnt_addr[AW+1:2];
            bus.mem_wdata = grant_d ? bus.d_req_wdata : 32'h0;
        end
    end

    // The round-robin pointer and pend_q record who owns next cycle's response.
    // The pointer resets to debug so that fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= OWN_DEBUG;
            pend_valid_q <= 1'b0;
            pend_owner_q <= OWN_FETCH;
            pend_err_q   <= 1'b0;
            pend_write_q <= 1'b0;
        end else begin
            if (grant_any) begin
                last_q <= grant_d ? OWN_DEBUG : OWN_FETCH;
            end
            pend_valid_q <= grant_any;
            pend_owner_q <= grant_d ? OWN_DEBUG : OWN_FETCH;
            pend_err_q   <= gnt_err;
            pend_write_q <= gnt_write;
        end
    end

    // Response routing. A response that falls due during reset is dropped.
    // A fetch response is also dropped while f_flush is high. Data is zero
    // unless a legal read produced it. An idle port shows all zeros.
    always_comb begin
        rsp_live = pend_valid_q & ~rst;
        f_live   = rsp_live & (pend_owner_q == OWN_FETCH) & ~bus.f_flush;
        d_live   = rsp_live & (pend_owner_q == OWN_DEBUG);
        rsp_data = (pend_err_q | pend_write_q) ? 32'h0 : bus.mem_rdata;

        bus.f_rsp_valid = f_live;
        bus.f_rsp_rdata = f_live ? rsp_data : 32'h0;
        bus.f_rsp_err   = f_live & pend_err_q;

        bus.d_rsp_valid = d_live;
        bus.d_rsp_rdata = d_live ? rsp_data : 32'h0;
        bus.d_rsp_err   = d_live & pend_err_q;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
// Drives imem_port_arbiter through a table of per-cycle vectors. Each vector
// holds the request inputs plus the hand-derived grant and memory-strobe
// expectations. Responses are checked against a scoreboard queue: an entry is
// pushed when a grant is expected and popped one cycle later. A shadow copy of
// memory supplies the expected read data. A behavioural single-port RAM
// answers the DUT's memory port.
module tb_imem_port_arbiter;

    localparam int DEPTH = 256;

    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] fa;
        logic        fl;
        logic        dv;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        exp_fr;
        logic        exp_dr;
        logic        exp_en;
        logic [7:0]  exp_addr;
    } vec_t;

    typedef struct {
        logic        is_fetch;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic [31:0] mem_arr [DEPTH];
    logic [31:0] shadow  [DEPTH];
    logic        mem_loaded;
    rsp_t        sbq [$];
    vec_t        vecs [27];
    int          check_count;
    int          pass_count;
    int          cyc;

    imem_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    imem_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with 10-time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Initial memory image: word 2 holds an addi instruction, and every other
    // word is tagged with its own index.
    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h0010_0093 : (32'hC0DE_0000 | i);
    endfunction

    // Single-port synchronous RAM. When no read takes place, rdata holds
    // garbage, so a response path that fails to zero its data shows up.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            mem_arr[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_arr[bus.mem_addr];
        else                           bus.mem_rdata <= 32'hBAAD_F00D;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
    endfunction

    function automatic vec_t mk_vec(
        input logic rst_i, input logic fv, input logic [31:0] fa, input logic fl,
        input logic dv, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
        input logic efr, input logic edr, input logic een, input logic [7:0] eaddr);
        vec_t v;
        v.rst = rst_i; v.fv = fv; v.fa = fa; v.fl = fl;
        v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.exp_fr = efr; v.exp_dr = edr; v.exp_en = een; v.exp_addr = eaddr;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    endtask

    // Compare the grant and memory strobes against the vector. Then compare
    // the response ports against the scoreboard entry that falls due now.
    task automatic checkOutput(input vec_t v);
        rsp_t        e;
        logic        efv, edv, efe, ede;
        logic [31:0] efd, edd;
        check_val("f_req_ready", {31'h0, bus.f_req_ready}, {31'h0, v.exp_fr});
        check_val("d_req_ready", {31'h0, bus.d_req_ready}, {31'h0, v.exp_dr});
        check_val("mem_en",      {31'h0, bus.mem_en},      {31'h0, v.exp_en});
        check_val("mem_addr",    {24'h0, bus.mem_addr},    v.exp_en ? {24'h0, v.exp_addr} : 32'h0);
        check_val("mem_we",      {31'h0, bus.mem_we},      {31'h0, v.exp_en & v.exp_dr & v.dwe});
        check_val("mem_wdata",   bus.mem_wdata,            (v.exp_en && v.exp_dr) ? v.dwd : 32'h0);

        efv = 1'b0; edv = 1'b0; efe = 1'b0; ede = 1'b0; efd = 32'h0; edd = 32'h0;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (!v.rst) begin
                if (e.is_fetch) begin
                    if (!v.fl) begin
                        efv = 1'b1; efd = e.rdata; efe = e.err;
                    end
                end else begin
                    edv = 1'b1; edd = e.rdata; ede = e.err;
                end
            end
        end
        check_val("f_rsp_valid", {31'h0, bus.f_rsp_valid}, {31'h0, efv});
        check_val("f_rsp_rdata", bus.f_rsp_rdata,          efd);
        check_val("f_rsp_err",   {31'h0, bus.f_rsp_err},   {31'h0, efe});
        check_val("d_rsp_valid", {31'h0, bus.d_rsp_valid}, {31'h0, edv});
        check_val("d_rsp_rdata", bus.d_rsp_rdata,          edd);
        check_val("d_rsp_err",   {31'h0, bus.d_rsp_err},   {31'h0, ede});
    endtask

    // Drive one cycle's inputs just after the clock edge and check mid-cycle.
    // Then queue the response each expected grant should produce next cycle.
    task automatic applyStimulus(input vec_t v);
        logic err;
        @(posedge clk);
        #1;
        rst             = v.rst;
        bus.f_req_valid = v.fv;
        bus.f_req_addr  = v.fa;
        bus.f_flush     = v.fl;
        bus.d_req_valid = v.dv;
        bus.d_req_we    = v.dwe;
        bus.d_req_addr  = v.da;
        bus.d_req_wdata = v.dwd;
        #4;
        checkOutput(v);
        if (v.exp_fr) begin
            err = addr_err(v.fa);
            sbq.push_back('{is_fetch: 1'b1, rdata: err ? 32'h0 : shadow[v.fa[9:2]], err: err});
        end
        if (v.exp_dr) begin
            err = addr_err(v.da);
            sbq.push_back('{is_fetch: 1'b0,
                            rdata: (err || v.dwe) ? 32'h0 : shadow[v.da[9:2]], err: err});
            if (!err && v.dwe) shadow[v.da[9:2]] = v.dwd;
        end
        cyc++;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        cyc         = 0;
        mem_loaded  = 1'b0;
        rst             = 1'b1;
        bus.f_req_valid = 1'b0;
        bus.f_req_addr  = 32'h0;
        bus.f_flush     = 1'b0;
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = 32'h0;
        bus.d_req_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);

        //                rst fv  fa          fl  dv  dwe da          dwd           fr  dr  en  addr
        // During reset, both readies stay low even though both ports request
        vecs[0]  = mk_vec(1, 1, 32'h0000_0008, 0, 1, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);
        vecs[1]  = mk_vec(1, 1, 32'h0000_0008, 0, 1, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);
        // Single fetch of word 2; its response is checked on the idle cycle
        vecs[2]  = mk_vec(0, 1, 32'h0000_0008, 0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 1, 8'd2);
        vecs[3]  = mk_vec(0, 0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);
        // Reset again, then continuous contention: grants go f,d,f,d,f,d
        vecs[4]  = mk_vec(1, 0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);
        vecs[5]  = mk_vec(0, 1, 32'h0000_0000, 0, 1, 0, 32'h0000_0004, 32'h0,         1, 0, 1, 8'd0);
        vecs[6]  = mk_vec(0, 1, 32'h0000_0004, 0, 1, 0, 32'h0000_0004, 32'h0,         0, 1, 1, 8'd1);
        vecs[7]  = mk_vec(0, 1, 32'h0000_0004, 0, 1, 0, 32'h0000_0008, 32'h0,         1, 0, 1, 8'd1);
        vecs[8]  = mk_vec(0, 1, 32'h0000_0008, 0, 1, 0, 32'h0000_0008, 32'h0,         0, 1, 1, 8'd2);
        vecs[9]  = mk_vec(0, 1, 32'h0000_0008, 0, 1, 0, 32'h0000_000C, 32'h0,         1, 0, 1, 8'd2);
        vecs[10] = mk_vec(0, 1, 32'h0000_000C, 0, 1, 0, 32'h0000_000C, 32'h0,         0, 1, 1, 8'd3);
        vecs[11] = mk_vec(0, 0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);
        // Debug write of word 4, then fetch readback
        vecs[12] = mk_vec(0, 0, 32'h0000_0000, 0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 1, 8'd4);
        vecs[13] = mk_vec(0, 1, 32'h0000_0010, 0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 1, 8'd4);
        vecs[14] = mk_vec(0, 0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);
        // Misaligned fetch, then out-of-range debug write: handshake, no mem access
        vecs[15] = mk_vec(0, 1, 32'h0000_0402, 0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 0, 8'd0);
        vecs[16] = mk_vec(0, 0, 32'h0000_0000, 0, 1, 1, 32'h0000_0400, 32'h1234_5678, 0, 1, 0, 8'd0);
        vecs[17] = mk_vec(0, 0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);
        // Fetch accepted, then flushed the next cycle while a debug read is granted
        vecs[18] = mk_vec(0, 1, 32'h0000_0014, 0, 1, 0, 32'h0000_0018, 32'h0,         1, 0, 1, 8'd5);
        vecs[19] = mk_vec(0, 1, 32'h0000_0018, 1, 1, 0, 32'h0000_0018, 32'h0,         0, 1, 1, 8'd6);
        vecs[20] = mk_vec(0, 1, 32'h0000_0018, 0, 0, 0, 32'h0000_0000, 32'h0,         1, 0, 1, 8'd6);
        vecs[21] = mk_vec(0, 0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);
        // Debug read whose response falls due in a reset cycle; then a tie goes to fetch
        vecs[22] = mk_vec(0, 0, 32'h0000_0000, 0, 1, 0, 32'h0000_001C, 32'h0,         0, 1, 1, 8'd7);
        vecs[23] = mk_vec(1, 1, 32'h0000_0000, 0, 1, 0, 32'h0000_0020, 32'h0,         0, 0, 0, 8'd0);
        vecs[24] = mk_vec(0, 1, 32'h0000_0000, 0, 1, 0, 32'h0000_0020, 32'h0,         1, 0, 1, 8'd0);
        vecs[25] = mk_vec(0, 0, 32'h0000_0000, 0, 1, 0, 32'h0000_0020, 32'h0,         0, 1, 1, 8'd8);
        vecs[26] = mk_vec(0, 0, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0,         0, 0, 0, 8'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Memory contents after the run. The rejected write to 0x400 must not
        // alias onto word 0. The debug write must have landed in word 4.
        @(posedge clk);
        #1;
        check_val("mem[0] unchanged", mem_arr[0], init_word(0));
        check_val("mem[4] written",   mem_arr[4], 32'hDEAD_BEEF);
        check_val("mem[2] unchanged", mem_arr[2], 32'h0010_0093);
        check_val("scoreboard drained", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
